// File: rtl/mdu_ctrl_pkg.sv
// ============================================================================
// Module      : mdu_ctrl_pkg
// Description : Shared MDU op encodings, controller state enum and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_ctrl_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;
  localparam logic [2:0] MD_MSUB  = 3'd7;

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Ops that occupy the unit for a multi-cycle period once accepted.
  function automatic logic md_is_start(input logic [2:0] op, input logic madd_en);
    md_is_start = (op == MD_MULT) || (op == MD_MULTU) ||
                  (op == MD_DIV)  || (op == MD_DIVU)  ||
                  (madd_en && ((op == MD_MADD) || (op == MD_MSUB)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ============================================================================
// Module      : mdu_arith
// Description : Combinational multiply / divide / multiply-accumulate datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [63:0] i_acc,
  output logic [63:0] o_result,
  output logic        o_div_zero
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_div_b;
  logic [31:0] w_quo_mag;
  logic [31:0] w_rem_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // Low 64 bits of a 64x64 product of sign-extended operands is the signed product.
  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Signed division on magnitudes: quotient truncates toward zero, remainder follows dividend.
  assign w_div_signed = (i_op == MD_DIV);
  assign w_neg_a      = w_div_signed & i_a[31];
  assign w_neg_b      = w_div_signed & i_b[31];
  assign w_mag_a      = w_neg_a ? (32'd0 - i_a) : i_a;
  assign w_mag_b      = w_neg_b ? (32'd0 - i_b) : i_b;
  assign w_div_b      = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_quo_mag    = w_mag_a / w_div_b;
  assign w_rem_mag    = w_mag_a % w_div_b;
  assign w_quo        = (w_neg_a ^ w_neg_b) ? (32'd0 - w_quo_mag) : w_quo_mag;
  assign w_rem        = w_neg_a ? (32'd0 - w_rem_mag) : w_rem_mag;

  assign o_div_zero = ((i_op == MD_DIV) || (i_op == MD_DIVU)) && (i_b == 32'd0);

  always_comb begin
    o_result = 64'd0;
    case (i_op)
      MD_MULT:          o_result = w_prod_s;
      MD_MULTU:         o_result = w_prod_u;
      MD_DIV, MD_DIVU:  o_result = {w_rem, w_quo};
      MD_MADD:          o_result = i_acc + w_prod_s;
      MD_MSUB:          o_result = i_acc - w_prod_s;
      default:          o_result = 64'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module      : mdu_ctrl
// Description : Multi-cycle MDU controller with HI/LO and pipeline stall.
//               Define MDU_MADD_EN to enable madd/msub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_uses_md,
  input  logic        rd_hi,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

`ifdef MDU_MADD_EN
  localparam logic c_madd_en = 1'b1;
`else
  localparam logic c_madd_en = 1'b0;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_op;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_capture;
  logic        w_finish;
  logic        w_wr_hi;
  logic        w_wr_lo;
  logic [63:0] w_result;
  logic        w_div_zero;

  mdu_arith u_arith (
    .i_op       (r_op),
    .i_a        (r_a),
    .i_b        (r_b),
    .i_acc      ({r_hi, r_lo}),
    .o_result   (w_result),
    .o_div_zero (w_div_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_finish    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (op_valid) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              w_state_nxt = ST_MUL;
              w_cnt_nxt   = MUL_CYCLES;
              w_capture   = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              w_state_nxt = ST_DIV;
              w_cnt_nxt   = DIV_CYCLES;
              w_capture   = 1'b1;
            end
            MD_MTHI: w_wr_hi = 1'b1;
            MD_MTLO: w_wr_lo = 1'b1;
            MD_MADD, MD_MSUB: begin
              if (c_madd_en) begin
                w_state_nxt = ST_MUL;
                w_cnt_nxt   = MUL_CYCLES;
                w_capture   = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        // New ops are ignored here; the pipeline is held off by stall_d.
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_op    <= MD_MULT;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= md_op;
      end
      // A divide by zero runs its full period but leaves HI/LO untouched.
      if (w_finish) begin
        if (!w_div_zero) begin
          r_hi <= w_result[63:32];
          r_lo <= w_result[31:0];
        end
      end else begin
        if (w_wr_hi) r_hi <= a;
        if (w_wr_lo) r_lo <= a;
      end
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign stall_d = d_uses_md & (busy | (op_valid & md_is_start(md_op, c_madd_en)));
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign rd_data = rd_hi ? r_hi : r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Randomised scoreboard bench for mdu_ctrl against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;

`ifdef MDU_MADD_EN
  localparam bit c_madd_en = 1'b1;
`else
  localparam bit c_madd_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_uses_md;
  logic        rd_hi;
  logic        busy;
  logic        stall_d;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .md_op     (md_op),
    .a         (a),
    .b         (b),
    .d_uses_md (d_uses_md),
    .rd_hi     (rd_hi),
    .busy      (busy),
    .stall_d   (stall_d),
    .hi        (hi),
    .lo        (lo),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cycles;
    logic [63:0] hilo;
  } sb_t;

  sb_t         sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state, advanced once per clock edge.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_busy_left = 0;
  int          m_total = 0;
  logic [63:0] m_pend = 64'd0;
  logic        m_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit starts_period(input logic [2:0] op);
    return (op <= 3'd3) || (c_madd_en && op >= 3'd6);
  endfunction

  // Result from plain 64-bit arithmetic; ok=0 means HI/LO must stay unchanged.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] acc,
                                             output logic ok);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    logic [63:0] ux = {32'd0, x};
    logic [63:0] uy = {32'd0, y};
    logic [63:0] r;
    ok = 1'b1;
    r  = 64'd0;
    case (op)
      3'd0: r = 64'(sx * sy);
      3'd1: r = ux * uy;
      3'd2: if (y == 0) ok = 1'b0; else r = {32'(sx % sy), 32'(sx / sy)};
      3'd3: if (y == 0) ok = 1'b0; else r = {32'(ux % uy), 32'(ux / uy)};
      3'd6: r = acc + 64'(sx * sy);
      3'd7: r = acc - 64'(sx * sy);
      default: ok = 1'b0;
    endcase
    return r;
  endfunction

  // Apply inputs for one cycle, check combinational/registered outputs, advance model.
  task automatic step(input logic rst, input logic v, input logic [2:0] op,
                      input logic [31:0] aa, input logic [31:0] bb,
                      input logic du, input logic rh);
    logic exp_busy;
    sb_t  item;
    reset = rst; op_valid = v; md_op = op; a = aa; b = bb; d_uses_md = du; rd_hi = rh;
    #1;
    exp_busy = (m_busy_left > 0);
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("stall_d", {31'd0, stall_d}, {31'd0, du & (exp_busy | (v & starts_period(op)))});
    chk("rd_data", rd_data, rh ? m_hi : m_lo);
    if (rst) begin
      if (m_busy_left > 0) begin
        void'(sb_q.pop_back());
        item.cycles = 32'(m_total - m_busy_left + 1);
        item.hilo   = 64'd0;
        sb_q.push_back(item);
      end
      m_hi = 32'd0; m_lo = 32'd0; m_busy_left = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0 && m_ok) {m_hi, m_lo} = m_pend;
    end else if (v) begin
      if (op == 3'd4) m_hi = aa;
      else if (op == 3'd5) m_lo = aa;
      else if (starts_period(op)) begin
        m_total     = (op == 3'd2 || op == 3'd3) ? 10 : 5;
        m_busy_left = m_total;
        m_pend      = ref_result(op, aa, bb, {m_hi, m_lo}, m_ok);
        item.cycles = 32'(m_total);
        item.hilo   = m_ok ? m_pend : {m_hi, m_lo};
        sb_q.push_back(item);
      end
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        input logic du);
    step(1'b0, 1'b1, op, aa, bb, du, 1'b1);
    while (m_busy_left > 0)
      step(1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom, du, 1'($urandom));
    step(1'b0, 1'b0, 3'd0, $urandom, $urandom, du, 1'b0);
  endtask

  // Monitor: each completed busy period is matched against the oldest expectation.
  int run_len = 0;
  always @(negedge clk) begin
    sb_t item;
    if (busy === 1'b1) begin
      run_len++;
    end else if (run_len > 0) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_busy", 32'(run_len), 32'd0);
      end else begin
        item = sb_q.pop_front();
        chk("sb_cycles", 32'(run_len), item.cycles);
        chk("sb_hi", hi, item.hilo[63:32]);
        chk("sb_lo", lo, item.hilo[31:0]);
      end
      run_len = 0;
    end
  end

  initial begin
    logic [31:0] rb;
    reset = 1'b1; op_valid = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
    d_uses_md = 1'b0; rd_hi = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset beats a concurrent start; stall_d only reflects the start term.
    step(1'b1, 1'b1, 3'd0, 32'h5, 32'h6, 1'b1, 1'b1);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    chk("mult_stall_after", {31'd0, stall_d}, 32'd0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    run_op(3'd3, 32'd7, 32'd2, 1'b0);
    chk("divu_hi", hi, 32'd1);
    chk("divu_lo", lo, 32'd3);

    step(1'b0, 1'b1, 3'd4, 32'h11, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'd5, 32'h22, 32'd0, 1'b0, 1'b0);
    run_op(3'd3, 32'd99, 32'd0, 1'b0);
    chk("divz_hi", hi, 32'h11);
    chk("divz_lo", lo, 32'h22);

    // Abort a divide on its third busy cycle.
    step(1'b0, 1'b1, 3'd2, 32'd100, 32'd7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'($urandom));
    chk("abort_late_hi", hi, 32'd0);
    chk("abort_late_lo", lo, 32'd0);

    step(1'b0, 1'b1, 3'd4, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    run_op(3'd6, 32'd1, 32'd1, 1'b1);
    chk("madd_hi", hi, c_madd_en ? 32'd1 : 32'd0);
    chk("madd_lo", lo, c_madd_en ? 32'd0 : 32'hFFFF_FFFF);

    for (int n = 0; n < 60; n++) begin
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 29) == 0)
        step(1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      run_op(3'($urandom_range(0, 7)), $urandom, rb, 1'($urandom));
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1, the rising-edge clock for all state.
REQ-002 The block SHALL have the port reset, input, 1, a synchronous active-high reset.
REQ-003 The block SHALL have the port op_valid, input, 1, which marks an MDU instruction present in the E stage this cycle.
REQ-004 The block SHALL have the port md_op, input, 3, with encoding 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 msub.
REQ-005 The block SHALL have the ports a and b, input, 32 each, carrying the E-stage rs and rt operand values after forwarding.
REQ-006 The block SHALL have the port d_uses_md, input, 1, which indicates the D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo/madd/msub.
REQ-007 The block SHALL have the port rd_hi, input, 1, where 1 selects HI and 0 selects LO for the mfhi/mflo read.
REQ-008 The block SHALL have the port busy, output, 1, which is high while a multi-cycle operation is in flight.
REQ-009 The block SHALL have the port stall_d, output, 1, which freezes PC and the D register and bubbles the E register.
REQ-010 The block SHALL have the ports hi and lo, output, 32 each, giving the architectural HI and LO register values.
REQ-011 The block SHALL have the port rd_data, output, 32, equal to hi when rd_hi is 1 and to lo otherwise (combinational).

Function
REQ-012 The controller SHALL be an FSM with the states IDLE, MUL and DIV, plus a 4-bit down-counter cnt.
REQ-013 In IDLE with op_valid and md_op in {0,1} at edge T, the block SHALL capture a and b, enter MUL, and load cnt=5.
REQ-014 In IDLE with op_valid and md_op in {2,3} at edge T, the block SHALL capture a and b, enter DIV, and load cnt=10.
REQ-015 busy SHALL be 1 exactly when the state is not IDLE, i.e. for 5 cycles for MUL and 10 cycles for DIV after the start edge.
REQ-016 cnt SHALL decrement every cycle; when cnt==1, the next edge SHALL write HI/LO and return to IDLE.
REQ-017 The new HI/LO values SHALL become visible on the cycle busy falls.
REQ-018 mult SHALL compute the signed 64-bit product and multu the unsigned 64-bit product, with HI = [63:32] and LO = [31:0].
REQ-019 div/divu SHALL produce LO = quotient and HI = remainder, signed or unsigned per op, with the remainder taking the sign of the dividend.
REQ-020 For div or divu with b==0, the block SHALL count the full 10 cycles and leave HI and LO unchanged.
REQ-021 mthi/mtlo in IDLE SHALL write a into HI/LO at that edge with no busy period.
REQ-022 Any op_valid while busy SHALL be ignored (no state change), since stall_d prevents this in a correct pipeline.
REQ-023 stall_d SHALL equal d_uses_md & (busy | (op_valid & md_op in {0,1,2,3,6,7})).
REQ-024 stall_d SHALL be purely combinational.
REQ-025 When op_valid starts an operation and busy is 0 in the same cycle, the start SHALL be accepted normally.
REQ-026 Operands captured at the start edge SHALL be used for the result, regardless of later changes on a and b.

Reset
REQ-027 On reset the block SHALL set state=IDLE, cnt=0, hi=0, lo=0, captured operands=0, busy=0, and stall_d=d_uses_md & start-term only.
REQ-028 Reset during MUL or DIV SHALL abort the operation, discard the pending result, and leave HI/LO=0.
REQ-029 Reset SHALL take priority over op_valid in the same cycle.

Configuration
REQ-030 When MDU_MADD_EN is defined, madd/msub SHALL enter MUL for 5 cycles and then write {HI,LO} ± the signed product, with 64-bit wrap-around.
REQ-031 When MDU_MADD_EN is undefined, md_op 6 and 7 SHALL be no-ops with no busy period and no HI/LO change, and SHALL be excluded from the stall_d start term.

Structure
REQ-032 A shared package SHALL hold the md_op encodings, the state enum, and the constants MUL_CYCLES=5 and DIV_CYCLES=10.
REQ-033 The FSM/counter and HI/LO SHALL reside in mdu_ctrl.
REQ-034 Arithmetic SHALL be in one sub-module, mdu_arith: combinational, taking captured operands and op, and producing the 64-bit result and a div-by-zero flag.

Verification
REQ-035 The bench SHALL check: mult a=0xFFFFFFFF, b=2 -> busy 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFE; multu with the same operands -> hi=1, lo=0xFFFFFFFE.
REQ-036 The bench SHALL check: div a=-7, b=2 -> busy 10 cycles, then lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1); divu a=7, b=2 -> lo=3, hi=1.
REQ-037 The bench SHALL check: divu with b=0 after mthi 0x11/mtlo 0x22 -> busy 10 cycles, and hi=0x11, lo=0x22 remain unchanged.
REQ-038 The bench SHALL check: mult start with d_uses_md=1 the same cycle -> stall_d=1 on that cycle and all 5 busy cycles, then 0 after busy falls.
REQ-039 The bench SHALL check: reset asserted on the 3rd busy cycle of div -> next cycle busy=0, hi=lo=0, and no later write.
REQ-040 With MDU_MADD_EN defined, the bench SHALL check: hi=0, lo=0xFFFFFFFF, then madd a=1, b=1 -> hi=1, lo=0; without the macro, the same op leaves hi/lo unchanged and busy=0.
